// File: rtl/zero_scan_if.sv
// Operand/handshake bundle for zero_scan: start/a toward the scanner, busy/done/zero/lzc back.
// The master drives requests; the slave (zero_scan) returns status and results.
interface zero_scan_if #(
    parameter int WIDTH = 16
);
    localparam int LZW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic             zero;
    logic [LZW-1:0]   lzc;

    modport master (
        output start, a,
        input  busy, done, zero, lzc
    );

    modport slave (
        input  start, a,
        output busy, done, zero, lzc
    );
endinterface

// File: rtl/zero_scan.sv
// Multi-cycle zero detector / leading-zero counter, scanning CHUNK bits per cycle MSB-first.
// Define ZERO_SCAN_EARLY_EXIT_EN to stop at the first nonzero chunk; otherwise latency is fixed at NCHUNK.
module zero_scan #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic       clk,
    input  logic       rst,
    zero_scan_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int LZW    = $clog2(WIDTH + 1);
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd;
    logic [KW-1:0]    k;
    logic             busy_r;
    logic             done_r;
    logic             zero_r;
    logic [LZW-1:0]   lzc_r;
`ifndef ZERO_SCAN_EARLY_EXIT_EN
    logic             hit;
    logic [LZW-1:0]   hit_lzc;
`endif

    logic [CHUNK-1:0] cur;
    logic             cur_nz;
    logic             last;
    logic [LZW-1:0]   cand;

    // Leading zeros inside one chunk; an all-zero chunk yields CHUNK.
    function automatic logic [LZW-1:0] chunk_lz(input logic [CHUNK-1:0] c);
        logic [LZW-1:0] n;
        logic           seen;
        n    = '0;
        seen = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (c[i])
                seen = 1'b1;
            else if (!seen)
                n = n + LZW'(1);
        end
        return n;
    endfunction

    // The operand is shifted left each cycle, so the chunk under test is always at the top.
    always_comb begin
        cur    = opnd[WIDTH-1 -: CHUNK];
        cur_nz = |cur;
        last   = (k == KW'(NCHUNK - 1));
        cand   = LZW'(k) * LZW'(CHUNK) + chunk_lz(cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            opnd    <= '0;
            k       <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            zero_r  <= 1'b0;
            lzc_r   <= '0;
`ifndef ZERO_SCAN_EARLY_EXIT_EN
            hit     <= 1'b0;
            hit_lzc <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opnd   <= bus.a;
                        k      <= '0;
                        busy_r <= 1'b1;
                        state  <= SCAN;
`ifndef ZERO_SCAN_EARLY_EXIT_EN
                        hit    <= 1'b0;
`endif
                    end
                end
                SCAN: begin
`ifdef ZERO_SCAN_EARLY_EXIT_EN
                    if (cur_nz || last) begin
                        zero_r <= ~cur_nz;
                        lzc_r  <= cand;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        k    <= k + KW'(1);
                        opnd <= opnd << CHUNK;
                    end
`else
                    // Remember the first nonzero chunk; later chunks must not disturb it.
                    if (!hit && cur_nz) begin
                        hit     <= 1'b1;
                        hit_lzc <= cand;
                    end
                    if (last) begin
                        zero_r <= ~(hit | cur_nz);
                        lzc_r  <= hit ? hit_lzc : cand;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        k    <= k + KW'(1);
                        opnd <= opnd << CHUNK;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.zero = zero_r;
    assign bus.lzc  = lzc_r;
endmodule
